// File: rtl/seg_pkg.sv
// Shared types and segment constants for the seven-segment display driver.
// Segment codes are {a,b,c,d,e,f,g,dp}, active-low, with dp always off (1).
package seg_pkg;

  typedef logic [7:0] seg_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    RENDER = 2'd2
  } state_e;

  localparam seg_t Seg0     = {7'b0000001, 1'b1};
  localparam seg_t Seg1     = {7'b1001111, 1'b1};
  localparam seg_t Seg2     = {7'b0010010, 1'b1};
  localparam seg_t Seg3     = {7'b0000110, 1'b1};
  localparam seg_t Seg4     = {7'b1001100, 1'b1};
  localparam seg_t Seg5     = {7'b0100100, 1'b1};
  localparam seg_t Seg6     = {7'b0100000, 1'b1};
  localparam seg_t Seg7     = {7'b0001111, 1'b1};
  localparam seg_t Seg8     = {7'b0000000, 1'b1};
  localparam seg_t Seg9     = {7'b0000100, 1'b1};
  localparam seg_t SegA     = {7'b0001000, 1'b1};
  localparam seg_t SegB     = {7'b1100000, 1'b1};
  localparam seg_t SegC     = {7'b0110001, 1'b1};
  localparam seg_t SegD     = {7'b1000010, 1'b1};
  localparam seg_t SegE     = {7'b0110000, 1'b1};
  localparam seg_t SegF     = {7'b0111000, 1'b1};
  localparam seg_t SegMinus = {7'b1111110, 1'b1};
  localparam seg_t SegBlank = {7'b1111111, 1'b1};
  // Overflow marker shares the glyph of hex digit E.
  localparam seg_t SegErr   = SegE;

endpackage

// File: rtl/seg_digit_enc.sv
// Single-digit seven-segment encoder: 4-bit code plus blank/minus overrides.
module seg_digit_enc
  import seg_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       blank_i,
  input  logic       minus_i,
  output logic [7:0] seg_o
);

  // Blank wins over minus, minus wins over the digit glyph.
  always_comb begin
    seg_o = SegBlank;
    if (blank_i) begin
      seg_o = SegBlank;
    end else if (minus_i) begin
      seg_o = SegMinus;
    end else begin
      case (code_i)
        4'h0: seg_o = Seg0;
        4'h1: seg_o = Seg1;
        4'h2: seg_o = Seg2;
        4'h3: seg_o = Seg3;
        4'h4: seg_o = Seg4;
        4'h5: seg_o = Seg5;
        4'h6: seg_o = Seg6;
        4'h7: seg_o = Seg7;
        4'h8: seg_o = Seg8;
        4'h9: seg_o = Seg9;
        4'hA: seg_o = SegA;
        4'hB: seg_o = SegB;
        4'hC: seg_o = SegC;
        4'hD: seg_o = SegD;
        4'hE: seg_o = SegE;
        default: seg_o = SegF;
      endcase
    end
  end

endmodule

// File: rtl/seg_dec_display.sv
// Binary to seven-segment decimal display driver. Converts a WIDTH-bit value to BCD with
// shift-add-3 (one bit per cycle), then renders all DIGITS at once with leading-zero
// blanking, a floating minus sign and an overflow "E".
// Optional raw-hex display path is enabled by defining SEG_HEX_MODE_EN (adds port hex_i).
module seg_dec_display
  import seg_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DIGITS = 8,
  parameter bit          SIGNED = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
`ifdef SEG_HEX_MODE_EN
  input  logic                hex_i,
`endif
  input  logic [WIDTH-1:0]    value_i,
  output logic [8*DIGITS-1:0] seg_o,
  output logic                done_o,
  output logic                ovf_o
);

  localparam int unsigned CntW      = $clog2(WIDTH);
  localparam int unsigned BcdW      = 4 * DIGITS;
  localparam int unsigned HexDigits = (WIDTH + 3) / 4;
  localparam int unsigned PadDigits = (HexDigits > DIGITS) ? HexDigits : DIGITS;
  localparam int unsigned PadW      = 4 * PadDigits;
  localparam logic [8*DIGITS-1:0] SegReset = {{(DIGITS-1){SegBlank}}, Seg0};

  state_e                state_q, state_d;
  logic                  sign_q, sign_d;
  logic                  hex_q, hex_d;
  logic [WIDTH-1:0]      mag_q, mag_d;
  logic [BcdW-1:0]       bcd_q, bcd_d;
  logic                  carry_q, carry_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [8*DIGITS-1:0]   seg_q, seg_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;

  logic                  accept;
  logic                  hex_sel;
  logic                  value_neg;
  logic                  carry_out;
  logic [BcdW-1:0]       bcd_adj;
  logic [PadW-1:0]       mag_pad;
  logic [BcdW-1:0]       digit_val;
  logic [BcdW-1:0]       digit_code;
  logic [DIGITS-1:0]     digit_blank;
  logic [DIGITS-1:0]     digit_minus;
  logic [8*DIGITS-1:0]   seg_render;
  logic                  any_nz;
  logic                  hex_ovf;
  logic                  ovf_render;
  int                    msnz;

`ifdef SEG_HEX_MODE_EN
  assign hex_sel = hex_i;
`else
  assign hex_sel = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign accept    = in_valid & in_ready;
  // Hex display is always unsigned, so the sign is only taken in decimal mode.
  assign value_neg = SIGNED & value_i[WIDTH-1] & ~hex_sel;
  assign mag_pad   = PadW'(mag_q);

  // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
  always_comb begin
    bcd_adj = '0;
    for (int k = 0; k < DIGITS; k++) begin
      bcd_adj[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3 : bcd_q[4*k +: 4];
    end
  end

  // Next-state logic for the accept / convert / render sequence.
  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    hex_d     = hex_q;
    mag_d     = mag_q;
    bcd_d     = bcd_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    seg_d     = seg_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    carry_out = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sign_d  = value_neg;
          hex_d   = hex_sel;
          // Unsigned magnitude keeps the most negative value exact.
          mag_d   = value_neg ? (~value_i + 1'b1) : value_i;
          bcd_d   = '0;
          carry_d = 1'b0;
          cnt_d   = CntW'(WIDTH - 1);
          state_d = hex_sel ? RENDER : CONV;
        end
      end
      CONV: begin
        {carry_out, bcd_d, mag_d} = {bcd_adj, mag_q, 1'b0};
        carry_d = carry_q | carry_out;
        if (cnt_q == '0) begin
          state_d = RENDER;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RENDER: begin
        seg_d   = seg_render;
        done_d  = 1'b1;
        ovf_d   = ovf_render;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-digit value: raw nibbles in hex mode, BCD nibbles otherwise.
  always_comb begin
    digit_val = '0;
    for (int k = 0; k < DIGITS; k++) begin
      digit_val[4*k +: 4] = hex_q ? mag_pad[4*k +: 4] : bcd_q[4*k +: 4];
    end
  end

  // Locate the most significant nonzero digit and decide overflow.
  always_comb begin
    any_nz  = 1'b0;
    msnz    = 0;
    hex_ovf = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (digit_val[4*k +: 4] != 4'd0) begin
        any_nz = 1'b1;
        msnz   = k;
      end
    end
    for (int k = DIGITS; k < PadDigits; k++) begin
      if (mag_pad[4*k +: 4] != 4'd0) begin
        hex_ovf = 1'b1;
      end
    end
    // A negative value needs one free digit above its MS digit for the sign.
    ovf_render = hex_q ? hex_ovf
                       : (carry_q | (sign_q & any_nz & (msnz == int'(DIGITS) - 1)));
  end

  // Per-digit glyph selection: overflow "E", digit, floating minus or blank.
  always_comb begin
    digit_code  = '0;
    digit_blank = '0;
    digit_minus = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (ovf_render) begin
        digit_code[4*k +: 4] = 4'hE;
        digit_blank[k]       = (k != 0);
        digit_minus[k]       = 1'b0;
      end else begin
        digit_code[4*k +: 4] = digit_val[4*k +: 4];
        digit_minus[k]       = sign_q & any_nz & (k == msnz + 1);
        digit_blank[k]       = (k > msnz) & ~(sign_q & any_nz & (k == msnz + 1));
      end
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    seg_digit_enc u_enc (
      .code_i  (digit_code[4*g +: 4]),
      .blank_i (digit_blank[g]),
      .minus_i (digit_minus[g]),
      .seg_o   (seg_render[8*g +: 8])
    );
  end

  // State registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      hex_q   <= 1'b0;
      mag_q   <= '0;
      bcd_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      seg_q   <= SegReset;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      hex_q   <= hex_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign seg_o  = seg_q;
  assign done_o = done_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_seg_dec_display.sv
// Directed bench for seg_dec_display: default 32-bit/8-digit signed instance plus a small
// 8-bit/2-digit unsigned instance. Hex cases are compiled in when SEG_HEX_MODE_EN is defined.
module tb_seg_dec_display;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        hex_sel;
  logic [31:0] value;
  logic [63:0] seg;
  logic        done_o;
  logic        ovf_o;

  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_value;
  logic [15:0] s_seg;
  logic        s_done;
  logic        s_ovf;

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seg_dec_display u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
`ifdef SEG_HEX_MODE_EN
    .hex_i    (hex_sel),
`endif
    .value_i  (value),
    .seg_o    (seg),
    .done_o   (done_o),
    .ovf_o    (ovf_o)
  );

  seg_dec_display #(
    .WIDTH  (8),
    .DIGITS (2),
    .SIGNED (1'b0)
  ) u_small (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (s_valid),
    .in_ready (s_ready),
`ifdef SEG_HEX_MODE_EN
    .hex_i    (1'b0),
`endif
    .value_i  (s_value),
    .seg_o    (s_seg),
    .done_o   (s_done),
    .ovf_o    (s_ovf)
  );

  // Accept one value on the main instance and count edges until done_o (-1 on timeout).
  task automatic run_value(input logic [31:0] v, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    value    = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      if (done_o === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_small(input logic [7:0] v, output int lat);
    @(negedge clk);
    s_valid = 1'b1;
    s_value = v;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (s_done === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (seg !== 64'hFFFF_FFFF_FFFF_FF03) begin
      errors++; $display("FAIL reset_seg: got %h want %h", seg, 64'hFFFF_FFFF_FFFF_FF03);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    checks++;
    if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_o); end
    checks++;
    if (ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf_o); end
    checks++;
    if (s_seg !== 16'hFF03) begin errors++; $display("FAIL reset_small_seg: got %h want ff03", s_seg); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", in_ready); end
  endtask

  task automatic test_decimal();
    int lat;
    run_value(32'd12345, lat);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL dec_latency: got %0d want 33", lat); end
    checks++;
    if (seg !== 64'hFFFF_FF9F_250D_9949) begin
      errors++; $display("FAIL dec_12345_seg: got %h want %h", seg, 64'hFFFF_FF9F_250D_9949);
    end
    checks++;
    if (ovf_o !== 1'b0) begin errors++; $display("FAIL dec_12345_ovf: got %b want 0", ovf_o); end
    @(posedge clk);
    #1;
    checks++;
    if (done_o !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b want 0", done_o); end
    run_value(32'd99999999, lat);
    checks++;
    if (seg !== 64'h0909_0909_0909_0909 || ovf_o !== 1'b0) begin
      errors++; $display("FAIL dec_max_fit: got %h ovf %b want 0909090909090909 ovf 0", seg, ovf_o);
    end
  endtask

  task automatic test_negative();
    int lat;
    run_value(32'hFFFF_FFF9, lat);
    checks++;
    if (seg !== 64'hFFFF_FFFF_FFFF_FD1F) begin
      errors++; $display("FAIL neg7_seg: got %h want %h", seg, 64'hFFFF_FFFF_FFFF_FD1F);
    end
    checks++;
    if (ovf_o !== 1'b0) begin errors++; $display("FAIL neg7_ovf: got %b want 0", ovf_o); end
    run_value(32'd0, lat);
    checks++;
    if (seg !== 64'hFFFF_FFFF_FFFF_FF03) begin
      errors++; $display("FAIL zero_seg: got %h want %h", seg, 64'hFFFF_FFFF_FFFF_FF03);
    end
  endtask

  task automatic test_overflow();
    int lat;
    run_value(32'd123456789, lat);
    checks++;
    if (seg !== 64'hFFFF_FFFF_FFFF_FF61) begin
      errors++; $display("FAIL ovf_big_seg: got %h want %h", seg, 64'hFFFF_FFFF_FFFF_FF61);
    end
    checks++;
    if (ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_big_flag: got %b want 1", ovf_o); end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (ovf_o !== 1'b1 || seg !== 64'hFFFF_FFFF_FFFF_FF61) begin
      errors++; $display("FAIL ovf_hold: got ovf %b seg %h want ovf 1 seg ffffffffffffff61", ovf_o, seg);
    end
    run_value(-32'sd9999999, lat);
    checks++;
    if (seg !== 64'hFD09_0909_0909_0909) begin
      errors++; $display("FAIL neg_fit_seg: got %h want %h", seg, 64'hFD09_0909_0909_0909);
    end
    checks++;
    if (ovf_o !== 1'b0) begin errors++; $display("FAIL neg_fit_ovf: got %b want 0", ovf_o); end
    run_value(-32'sd10000000, lat);
    checks++;
    if (ovf_o !== 1'b1 || seg !== 64'hFFFF_FFFF_FFFF_FF61) begin
      errors++; $display("FAIL neg_nofit: got ovf %b seg %h want ovf 1 seg ffffffffffffff61", ovf_o, seg);
    end
    run_value(32'h8000_0000, lat);
    checks++;
    if (ovf_o !== 1'b1) begin errors++; $display("FAIL min_int_ovf: got %b want 1", ovf_o); end
  endtask

  // in_valid held high with data changing every cycle: only edges 0, 34 and 68 accept.
  task automatic test_back_to_back();
    logic [63:0] prev;
    logic [63:0] exp;
    @(negedge clk);
    prev = seg;
    for (int c = 0; c <= 101; c++) begin
      in_valid = 1'b1;
      value    = 32'd1000 + 32'(c);
      @(posedge clk);
      #1;
      if (c == 33 || c == 67 || c == 101) begin
        exp = (c == 33) ? 64'hFFFF_FFFF_9F03_0303 :
              (c == 67) ? 64'hFFFF_FFFF_9F03_0D99 : 64'hFFFF_FFFF_9F03_4101;
        checks++;
        if (done_o !== 1'b1) begin errors++; $display("FAIL b2b_done c=%0d: got %b want 1", c, done_o); end
        checks++;
        if (seg !== exp) begin errors++; $display("FAIL b2b_seg c=%0d: got %h want %h", c, seg, exp); end
        prev = seg;
      end else begin
        checks++;
        if (done_o !== 1'b0 || seg !== prev) begin
          errors++; $display("FAIL b2b_quiet c=%0d: got done %b seg %h want done 0 seg %h", c, done_o, seg, prev);
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_conv();
    int lat;
    int seen_done;
    run_value(32'd123456789, lat);
    @(negedge clk);
    in_valid = 1'b1;
    value    = 32'd4321;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (seg !== 64'hFFFF_FFFF_FFFF_FF03 || ovf_o !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("FAIL midconv_reset: got seg %h ovf %b done %b want ffffffffffffff03 0 0", seg, ovf_o, done_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done_o === 1'b1) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin errors++; $display("FAIL midconv_no_done: got %0d pulses want 0", seen_done); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midconv_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_small();
    int lat;
    run_small(8'd99, lat);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL small_latency: got %0d want 9", lat); end
    checks++;
    if (s_seg !== 16'h0909 || s_ovf !== 1'b0) begin
      errors++; $display("FAIL small_99: got %h ovf %b want 0909 ovf 0", s_seg, s_ovf);
    end
    run_small(8'd5, lat);
    checks++;
    if (s_seg !== 16'hFF49) begin errors++; $display("FAIL small_5: got %h want ff49", s_seg); end
    run_small(8'd255, lat);
    checks++;
    if (s_seg !== 16'hFF61 || s_ovf !== 1'b1) begin
      errors++; $display("FAIL small_255: got %h ovf %b want ff61 ovf 1", s_seg, s_ovf);
    end
    run_small(8'd10, lat);
    checks++;
    if (s_seg !== 16'h9F03 || s_ovf !== 1'b0) begin
      errors++; $display("FAIL small_10: got %h ovf %b want 9f03 ovf 0", s_seg, s_ovf);
    end
  endtask

`ifdef SEG_HEX_MODE_EN
  task automatic test_hex();
    int lat;
    hex_sel = 1'b1;
    run_value(32'h00C0_FFEE, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL hex_latency: got %0d want 1", lat); end
    checks++;
    if (seg !== 64'hFFFF_6303_7171_6161) begin
      errors++; $display("FAIL hex_c0ffee: got %h want %h", seg, 64'hFFFF_6303_7171_6161);
    end
    run_value(32'hFFFF_FFFF, lat);
    checks++;
    if (seg !== 64'h7171_7171_7171_7171 || ovf_o !== 1'b0) begin
      errors++; $display("FAIL hex_all_f: got %h ovf %b want 7171717171717171 ovf 0", seg, ovf_o);
    end
    hex_sel = 1'b0;
  endtask
`endif

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    hex_sel  = 1'b0;
    value    = '0;
    s_valid  = 1'b0;
    s_value  = '0;
    test_reset();
    test_decimal();
    test_negative();
    test_overflow();
    test_back_to_back();
    test_reset_mid_conv();
    test_small();
`ifdef SEG_HEX_MODE_EN
    test_hex();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
